// File: rtl/rs_scheduler.sv
// Reservation station for the ALU path: holds issued entries, wakes operands from the CDB,
// and dispatches the lowest ready entry through a one-entry output register.
// Optional same-cycle CDB capture on push is enabled by defining RS_CDB_BYPASS_EN.
module rs_scheduler #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4,
  parameter int ROB_W    = 4,
  parameter int OP_W     = 6,
  parameter int DATA_W   = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  input  logic                push,
  input  logic [OP_W-1:0]     push_op,
  input  logic [DATA_W-1:0]   push_imm,
  input  logic [31:0]         push_pc,
  input  logic [ROB_W-1:0]    push_rob,
  input  logic [DATA_W-1:0]   push_vj,
  input  logic                push_qj_busy,
  input  logic [ROB_W-1:0]    push_qj,
  input  logic [DATA_W-1:0]   push_vk,
  input  logic                push_qk_busy,
  input  logic [ROB_W-1:0]    push_qk,
  output logic                avail,
  output logic [RS_IDX_W-1:0] avail_pos,
  input  logic                cdb_valid,
  input  logic [ROB_W-1:0]    cdb_rob,
  input  logic [DATA_W-1:0]   cdb_val,
  output logic                alu_valid,
  input  logic                alu_ready,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_vj,
  output logic [DATA_W-1:0]   alu_vk,
  output logic [DATA_W-1:0]   alu_imm,
  output logic [31:0]         alu_pc,
  output logic [ROB_W-1:0]    alu_rob,
  output logic [RS_IDX_W:0]   count
);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [OP_W-1:0]    e_op  [RS_SIZE];
  logic [DATA_W-1:0]  e_imm [RS_SIZE];
  logic [31:0]        e_pc  [RS_SIZE];
  logic [ROB_W-1:0]   e_rob [RS_SIZE];
  logic [DATA_W-1:0]  e_vj  [RS_SIZE];
  logic [DATA_W-1:0]  e_vk  [RS_SIZE];
  logic [ROB_W-1:0]   e_qj  [RS_SIZE];
  logic [ROB_W-1:0]   e_qk  [RS_SIZE];

  logic [RS_SIZE-1:0]  ready;
  logic                sel_valid;
  logic [RS_IDX_W-1:0] sel_idx;
  logic                out_load;

  logic                push_qj_wait;
  logic                push_qk_wait;
  logic [DATA_W-1:0]   push_vj_eff;
  logic [DATA_W-1:0]   push_vk_eff;

`ifdef RS_CDB_BYPASS_EN
  // A producer broadcasting in the push cycle is captured here, otherwise it would be missed.
  always_comb begin
    push_qj_wait = push_qj_busy;
    push_vj_eff  = push_vj;
    push_qk_wait = push_qk_busy;
    push_vk_eff  = push_vk;
    if (cdb_valid && push_qj_busy && (push_qj == cdb_rob)) begin
      push_qj_wait = 1'b0;
      push_vj_eff  = cdb_val;
    end
    if (cdb_valid && push_qk_busy && (push_qk == cdb_rob)) begin
      push_qk_wait = 1'b0;
      push_vk_eff  = cdb_val;
    end
  end
`else
  assign push_qj_wait = push_qj_busy;
  assign push_vj_eff  = push_vj;
  assign push_qk_wait = push_qk_busy;
  assign push_vk_eff  = push_vk;
`endif

  assign ready    = busy & ~qj_busy & ~qk_busy;
  assign avail    = ~&busy;
  assign out_load = !alu_valid || alu_ready;

  // Descending scans so the lowest index wins.
  always_comb begin
    avail_pos = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    count     = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) avail_pos = RS_IDX_W'(i);
      if (ready[i]) begin
        sel_valid = 1'b1;
        sel_idx   = RS_IDX_W'(i);
      end
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      count = count + {{RS_IDX_W{1'b0}}, busy[i]};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy    <= '0;
      qj_busy <= '0;
      qk_busy <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        e_op[i]  <= '0;
        e_imm[i] <= '0;
        e_pc[i]  <= '0;
        e_rob[i] <= '0;
        e_vj[i]  <= '0;
        e_vk[i]  <= '0;
        e_qj[i]  <= '0;
        e_qk[i]  <= '0;
      end
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_vj    <= '0;
      alu_vk    <= '0;
      alu_imm   <= '0;
      alu_pc    <= '0;
      alu_rob   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        busy      <= '0;
        qj_busy   <= '0;
        qk_busy   <= '0;
        alu_valid <= 1'b0;
      end else begin
        if (cdb_valid) begin
          for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && qj_busy[i] && (e_qj[i] == cdb_rob)) begin
              e_vj[i]    <= cdb_val;
              qj_busy[i] <= 1'b0;
            end
            if (busy[i] && qk_busy[i] && (e_qk[i] == cdb_rob)) begin
              e_vk[i]    <= cdb_val;
              qk_busy[i] <= 1'b0;
            end
          end
        end
        // The selected entry is fully ready, so the wakeup above never touches it.
        if (out_load) begin
          alu_valid <= sel_valid;
          if (sel_valid) begin
            busy[sel_idx] <= 1'b0;
            alu_op        <= e_op[sel_idx];
            alu_vj        <= e_vj[sel_idx];
            alu_vk        <= e_vk[sel_idx];
            alu_imm       <= e_imm[sel_idx];
            alu_pc        <= e_pc[sel_idx];
            alu_rob       <= e_rob[sel_idx];
          end
        end
        // Push targets a slot that is free now, so it never collides with the dispatch above.
        if (push && avail) begin
          busy[avail_pos]    <= 1'b1;
          qj_busy[avail_pos] <= push_qj_wait;
          qk_busy[avail_pos] <= push_qk_wait;
          e_op[avail_pos]    <= push_op;
          e_imm[avail_pos]   <= push_imm;
          e_pc[avail_pos]    <= push_pc;
          e_rob[avail_pos]   <= push_rob;
          e_vj[avail_pos]    <= push_vj_eff;
          e_vk[avail_pos]    <= push_vk_eff;
          e_qj[avail_pos]    <= push_qj;
          e_qk[avail_pos]    <= push_qk;
        end
      end
    end
  end

endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Reservation-station storage plus wakeup/select scheduler for the ALU path.
- Accepts issued instructions from the issue stage and snoops the CDB for ROB-tagged results to wake waiting operands.
- Each cycle, selects one fully-ready entry and dispatches it to the ALU with a valid/ready handshake.
- Reports a free slot back to issue and clears all entries on a ROB flush (mispredict).

Parameters:
- RS_SIZE, 16, number of entries; power of two, at least 2.
- RS_IDX_W, 4, log2(RS_SIZE).
- ROB_W, 4, ROB tag width.
- OP_W, 6, opcode width.
- DATA_W, 32, operand/result width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-high reset.
- rdy_in  in  1  global enable; when low, all state holds.
- flush  in  1  ROB mispredict; clear all entries.
- push  in  1  issue writes a new entry this cycle.
- push_op  in  OP_W  opcode.
- push_imm  in  DATA_W  immediate.
- push_pc  in  32  instruction PC.
- push_rob  in  ROB_W  destination ROB tag.
- push_vj  in  DATA_W  operand j value (valid when push_qj_busy=0).
- push_qj_busy  in  1  operand j waits on a tag.
- push_qj  in  ROB_W  tag for operand j.
- push_vk  in  DATA_W  operand k value.
- push_qk_busy  in  1  operand k waits on a tag.
- push_qk  in  ROB_W  tag for operand k.
- avail  out  1  at least one free entry.
- avail_pos  out  RS_IDX_W  lowest-index free entry.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_rob  in  ROB_W  broadcast tag.
- cdb_val  in  DATA_W  broadcast value.
- alu_valid  out  1  dispatch valid.
- alu_ready  in  1  ALU accepts.
- alu_op  out  OP_W  dispatched opcode.
- alu_vj  out  DATA_W  dispatched operand j.
- alu_vk  out  DATA_W  dispatched operand k.
- alu_imm  out  DATA_W  dispatched immediate.
- alu_pc  out  32  dispatched PC.
- alu_rob  out  ROB_W  dispatched destination tag.
- count  out  RS_IDX_W+1  number of occupied entries.

Behaviour:
- Reset (async, rst_in=1):
  - All entry busy bits are 0.
  - Output register is empty: alu_valid=0 and all alu_* data = 0.
  - count=0, avail=1, avail_pos=0.
- Combinational outputs:
  - avail = any entry not busy.
  - avail_pos = lowest free index (0 when none free).
  - count = popcount(busy).
- Push (rising edge, rdy_in=1, push=1, flush=0):
  - Writes the entry at the avail_pos sampled that cycle and sets its busy bit.
  - push while avail=0 is illegal; the scheduler ignores it (no overwrite, count unchanged).
- Wakeup (rising edge, cdb_valid=1):
  - Every busy entry with qj_busy and qj==cdb_rob takes vj<=cdb_val and clears qj_busy.
  - The same applies independently to k.
  - One broadcast can wake both operands of an entry and any number of entries.
- Ready condition: entry is busy, qj_busy=0 and qk_busy=0, evaluated on registered state. A wakeup makes the entry eligible on the next cycle.
- Select: lowest-index ready entry.
- Output stage:
  - One-entry register.
  - It loads when empty, or when alu_valid&&alu_ready (pipelined, one dispatch per cycle sustained).
  - On load, the selected entry's busy bit is cleared in the same edge.
  - Latency: an entry pushed with both operands ready shows alu_valid=1 exactly one cycle after its push edge.
  - alu_* fields are stable while alu_valid=1 and alu_ready=0.
- Dispatched operands are final: the output register does not snoop the CDB.
- Simultaneous events:
  - A push and a dispatch in the same cycle never target the same slot, because push uses a free slot.
  - A freed slot becomes available the next cycle.
  - A push with a tag matching the same-cycle CDB follows the Optional Feature.
- flush:
  - Highest priority; overrides push, wakeup and select.
  - Next edge: all busy=0, alu_valid=0, count=0.
- rdy_in=0: no state change. alu_valid and its data hold; an alu_ready handshake is not consumed.
- rst_in asserted mid-operation clears immediately, regardless of rdy_in.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- Defined: during a push, if cdb_valid and push_qj_busy and push_qj==cdb_rob, the entry stores vj=cdb_val with qj_busy=0. The same applies to k. Without this, an operand whose producer broadcasts in the push cycle would wait forever.
- Undefined: no bypass. Issue must resolve same-cycle CDB values before presenting push_*. The scheduler stores the push fields verbatim.

Test Plan:
- Reset then push op=3, vj=5, vk=7, both ready, alu_ready=1 -> alu_valid=1 next cycle with alu_vj=5, alu_vk=7, alu_op=3; count returns to 0.
- Push entry with qj_busy, qj=2; two cycles later cdb_valid, cdb_rob=2, cdb_val=0x1234 -> one cycle later alu_valid=1 with alu_vj=0x1234; tag 3 on the CDB causes no wakeup.
- Fill all 16 entries with unresolved tags -> avail=0, count=16; an illegal push changes nothing; waking entry 9 dispatches it and avail_pos=9 on the following cycle.
- Hold alu_ready=0 with three ready entries (0, 1, 2) -> alu_* frozen on entry 0; release -> entries 0, 1, 2 dispatch on consecutive cycles.
- Assert flush with 5 busy entries and alu_valid=1 in the same cycle as a push -> next cycle count=0, alu_valid=0, avail_pos=0.
- With RS_CDB_BYPASS_EN, push qj=4 while cdb_rob=4, cdb_val=9 -> dispatch with alu_vj=9. Without the macro -> the entry is still waiting after 10 cycles.
